// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - clocked move sequencer: owns the board, checks and commits moves
// Purpose: accepts one move request at a time over valid/ready, checks it against the
//          game rules in a fixed priority order, commits legal moves and returns a
//          one-cycle response carrying a numeric reject code.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   new_game            synchronous board clear, forces the FSM to IDLE
//   state               game state (INIT=0, PLAY=1, Awin=2, Bwin=3, DRAW=4)
//   req_valid/req_ready request handshake; req_player (A=01, B=10), req_cell (row-major)
//   rsp_valid           one-cycle response strobe with rsp_ok and rsp_code
//   board_a/board_b     per-player occupancy, bit i = cell i
//   turn, move_count    player to move, committed move count
//   board_full          move_count == CELLS
module move_sequencer #(
   parameter int         BOARD_N      = 3,
   parameter logic [1:0] FIRST_PLAYER = 2'b01,
   localparam int        CELLS        = BOARD_N * BOARD_N,
   localparam int        IDX_W        = (CELLS > 1) ? $clog2(CELLS) : 1,
   localparam int        CNT_W        = $clog2(CELLS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_game,
   input  logic [2:0]       state,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_player,
   input  logic [IDX_W-1:0] req_cell,
   output logic             rsp_valid,
   output logic             rsp_ok,
   output logic [2:0]       rsp_code,
   output logic [CELLS-1:0] board_a,
   output logic [CELLS-1:0] board_b,
   output logic [1:0]       turn,
   output logic [CNT_W-1:0] move_count,
   output logic             board_full
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [2:0] GS_PLAY  = 3'd1;
   localparam logic [1:0] PLAYER_A = 2'b01;
   localparam logic [1:0] PLAYER_B = 2'b10;

   localparam logic [IDX_W:0]   CELLS_X = (IDX_W + 1)'(CELLS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CELLS);
   localparam logic [CELLS-1:0] ONE_HOT = CELLS'(1);

   logic [1:0]       fsm_q, fsm_d;
   logic [1:0]       player_q, player_d;
   logic [IDX_W-1:0] cell_q, cell_d;
   logic             ok_q, ok_d;
   logic [2:0]       code_q, code_d;
   logic [CELLS-1:0] board_a_q, board_a_d;
   logic [CELLS-1:0] board_b_q, board_b_d;
   logic [1:0]       turn_q, turn_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [CELLS-1:0] occ_shift;
   logic [CELLS-1:0] cell_mask;
   logic             cell_taken;
   logic             full;

   // Shift instead of a direct bit-select so an out-of-range cell never indexes past the board.
   assign occ_shift  = (board_a_q | board_b_q) >> cell_q;
   assign cell_taken = occ_shift[0];
   assign cell_mask  = ONE_HOT << cell_q;
   assign full       = (count_q == CNT_MAX);

   // new_game blocks acceptance and suppresses any in-flight response in the same cycle.
   assign req_ready  = (fsm_q == S_IDLE) && !new_game;
   assign rsp_valid  = (fsm_q == S_RESP) && !new_game;
   assign rsp_ok     = rsp_valid && ok_q;
   assign rsp_code   = rsp_valid ? code_q : 3'd0;
   assign board_a    = board_a_q;
   assign board_b    = board_b_q;
   assign turn       = turn_q;
   assign move_count = count_q;
   assign board_full = full;

   always_comb begin
      fsm_d     = fsm_q;
      player_d  = player_q;
      cell_d    = cell_q;
      ok_d      = ok_q;
      code_d    = code_q;
      board_a_d = board_a_q;
      board_b_d = board_b_q;
      turn_d    = turn_q;
      count_d   = count_q;
      case (fsm_q)
         S_IDLE: begin
            if (req_valid) begin
               player_d = req_player;
               cell_d   = req_cell;
               fsm_d    = S_CHECK;
            end
         end
         S_CHECK: begin
            ok_d  = 1'b0;
            fsm_d = S_RESP;
            if (state != GS_PLAY)                                 code_d = 3'd1;
            else if ({1'b0, cell_q} >= CELLS_X)                   code_d = 3'd2;
            else if (player_q != PLAYER_A && player_q != PLAYER_B) code_d = 3'd3;
            else if (cell_taken)                                   code_d = 3'd4;
            else if (player_q != turn_q)                           code_d = 3'd5;
            else if (full)                                         code_d = 3'd6;
            else begin
               code_d = 3'd0;
               ok_d   = 1'b1;
            end
         end
         S_RESP: begin
            fsm_d = S_IDLE;
            if (ok_q) begin
               if (player_q == PLAYER_A) board_a_d = board_a_q | cell_mask;
               else                      board_b_d = board_b_q | cell_mask;
               turn_d = (turn_q == PLAYER_A) ? PLAYER_B : PLAYER_A;
               if (!full) count_d = count_q + CNT_W'(1);
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         fsm_q     <= S_IDLE;
         player_q  <= 2'b00;
         cell_q    <= '0;
         ok_q      <= 1'b0;
         code_q    <= 3'd0;
         board_a_q <= '0;
         board_b_q <= '0;
         turn_q    <= FIRST_PLAYER;
         count_q   <= '0;
      end else begin
         fsm_q     <= fsm_d;
         player_q  <= player_d;
         cell_q    <= cell_d;
         ok_q      <= ok_d;
         code_q    <= code_d;
         board_a_q <= board_a_d;
         board_b_q <= board_b_d;
         turn_q    <= turn_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Clocked, parametrised successor to the combinational move checker.
- Owns the N×N board registers for players A and B, plus the turn and move counter.
- Accepts one move request at a time over a valid/ready handshake and checks it against game rules.
- Commits legal moves, toggles the turn, and returns a one-cycle response with a numeric reject code. Numeric codes replace the printed diagnostics of the old checker. Sits between the input decoder and the win/draw evaluator.

Parameters:
- BOARD_N, 3, side length of the board; CELLS = BOARD_N*BOARD_N (range 3..8).
- FIRST_PLAYER, 2'b01, player that moves first after reset or new_game: A=2'b01, B=2'b10.
- IDX_W, derived localparam = clog2(CELLS), minimum 1; width of the cell index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  synchronous board clear. Same effect as rst on all state except the FSM, which goes to IDLE.
- state  in  3  game state: INIT=0, PLAY=1, Awin=2, Bwin=3, DRAW=4.
- req_valid  in  1  move request present.
- req_ready  out  1  sequencer can accept a request.
- req_player  in  2  requesting player: A=01, B=10.
- req_cell  in  IDX_W  cell index, row-major, 0..CELLS-1.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_ok  out  1  move accepted and committed. Valid only with rsp_valid.
- rsp_code  out  3  reject reason. Valid only with rsp_valid.
- board_a  out  CELLS  occupancy of player A, bit i = cell i.
- board_b  out  CELLS  occupancy of player B.
- turn  out  2  player whose move is expected.
- move_count  out  clog2(CELLS+1)  number of committed moves.
- board_full  out  1  move_count == CELLS.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - board_a=0, board_b=0, turn=FIRST_PLAYER, move_count=0, board_full=0.
  - rsp_valid=0, rsp_ok=0, rsp_code=0.
  - FSM=IDLE, req_ready=1 on the next cycle.
  - rst has priority over new_game and over any request.
- FSM states: IDLE, CHECK, RESP.
  - IDLE: req_ready=1. req_valid&req_ready at an edge latches player and cell and goes to CHECK.
  - CHECK: req_ready=0. Evaluates the rules against the registered board; result is registered; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; on an accept, the board, turn and count update at this same edge; go to IDLE.
- Latency: handshake at edge t; rsp_valid high during cycle t+2; board outputs reflect the commit from edge t+2.
- Throughput: one request per 3 cycles. A new handshake is possible at edge t+3.
- Rule checks, first failure wins:
  - 1 NOT_PLAY: state != PLAY, sampled in CHECK.
  - 2 BAD_CELL: req_cell >= CELLS. Only reachable when CELLS is not a power of 2.
  - 3 BAD_PLAYER: req_player not 01 or 10.
  - 4 CELL_TAKEN: board_a[cell] | board_b[cell].
  - 5 WRONG_TURN: req_player != turn.
  - 6 BOARD_FULL: board_full=1. Unreachable in normal play because of CELL_TAKEN; kept for robustness.
  - Otherwise rsp_ok=1, rsp_code=0.
- Commit on accept:
  - Set bit cell in the player's board.
  - turn toggles 01↔10.
  - move_count increments. It never exceeds CELLS.
- Reject: no architectural state changes.
- Invariant: board_a & board_b == 0 at all times.
- new_game:
  - In any state it clears the board, count and turn (to FIRST_PLAYER) and forces the FSM to IDLE.
  - Any in-flight request is dropped with no response; rsp_valid=0 that cycle.
  - new_game concurrent with req_valid in IDLE: the request is not accepted (req_ready is forced to 0 while new_game=1).
- req_player and req_cell are don't-care when req_valid=0.
- The state input may change at any time. Only its value during CHECK matters.

Test Plan:
- Reset, then state=PLAY, A requests cell 4 → rsp_valid at t+2, rsp_ok=1, code 0; board_a=9'h010; turn=10; move_count=1.
- Next, A requests cell 0 → rsp_ok=0, code 5; board unchanged, turn stays 10.
- B requests cell 4 → code 4; then B requests cell 8 → ok, board_b=9'h100, move_count=2.
- state=INIT, A requests a free cell → code 1. Also req_player=2'b11 in PLAY → code 3. Neither changes state.
- BOARD_N=3, cell=9 → code 2. Also BOARD_N=4, FIRST_PLAYER=B, fill all 16 cells alternately → board_full=1, move_count=16; a further request gives code 4.
- new_game asserted during CHECK → no rsp_valid pulse; boards=0, turn=FIRST_PLAYER, req_ready=1 next cycle. Also rst coincident with an accept in RESP → all outputs at reset values.
